wall_game_engine: RTL

Parametrised game-logic engine for the wall-dodging game. It is the successor to the single-wall logic in the top level. It moves the player block, scrolls `NUM_WALLS` independent walls with per-wall gaps, and runs the death/respawn sequence. It also drives the score counter's `reset`/`stop` controls. It sits between the button inputs and the draw controller. All updates advance on a one-cycle `tick` enable (frame rate), never on a derived clock.

---
 rtl/wall_game_engine.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/wall_game_engine.sv
// wall_game_engine: game logic for the wall-dodging game.
// Moves the player block, scrolls NUM_WALLS walls with per-wall gaps, runs
// the death/respawn sequence and drives the score counter controls.
// Everything advances on the one-cycle `tick` frame enable.
// Optional feature macro: WALL_ENGINE_SPEEDUP_EN (wall speed ramps up with wraps).
module wall_game_engine #(
   parameter int NUM_WALLS     = 2,
   parameter int COORD_W       = 11,
   parameter int BLK_STEP      = 3,
   parameter int WALL_STEP     = 4,
   parameter int WALL_WRAP     = 1429,
   parameter int GAP_INIT      = 150,
   parameter int GAP_MIN       = 45,
   parameter int GAP_DEC       = 10,
   parameter int RESPAWN_TICKS = 400
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           tick,
   input  logic                           sw_up,
   input  logic                           sw_down,
   input  logic                           sw_left,
   input  logic                           sw_right,
   input  logic                           collide,
   output logic [COORD_W-1:0]             blk_x,
   output logic [COORD_W-1:0]             blk_y,
   output logic [NUM_WALLS*COORD_W-1:0]   wall_x,
   output logic [NUM_WALLS*COORD_W-1:0]   gap_y,
   output logic [COORD_W-1:0]             gap_size,
   output logic                           score_reset,
   output logic                           score_stop,
   output logic                           dead
);

   localparam int CNT_W = $clog2(RESPAWN_TICKS) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RESPAWN_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_SR_LO = CNT_W'(RESPAWN_TICKS - 40);

   localparam logic [COORD_W-1:0] BLK_X_INIT = COORD_W'(704);
   localparam logic [COORD_W-1:0] BLK_Y_INIT = COORD_W'(435);
   localparam logic [COORD_W-1:0] X_MIN      = COORD_W'(10);
   localparam logic [COORD_W-1:0] X_MAX      = COORD_W'(1396);
   localparam logic [COORD_W-1:0] Y_MIN      = COORD_W'(14);
   localparam logic [COORD_W-1:0] Y_MAX      = COORD_W'(856);
   localparam logic [COORD_W-1:0] STEP       = COORD_W'(BLK_STEP);
   // Thresholds at which one more step would cross a bound
   localparam logic [COORD_W-1:0] X_LO_TH    = COORD_W'(10 + BLK_STEP);
   localparam logic [COORD_W-1:0] X_HI_TH    = COORD_W'(1396 - BLK_STEP);
   localparam logic [COORD_W-1:0] Y_LO_TH    = COORD_W'(14 + BLK_STEP);
   localparam logic [COORD_W-1:0] Y_HI_TH    = COORD_W'(856 - BLK_STEP);

   localparam logic [COORD_W-1:0] GAP_Y_INIT = COORD_W'(400);
   localparam logic [COORD_W-1:0] WRAP_C     = COORD_W'(WALL_WRAP);
   localparam logic [COORD_W-1:0] GAP_INIT_C = COORD_W'(GAP_INIT);
   localparam logic [COORD_W-1:0] GAP_MIN_C  = COORD_W'(GAP_MIN);
   localparam logic [COORD_W-1:0] GAP_DEC_C  = COORD_W'(GAP_DEC);
   // Gap arithmetic is done one bit wider than a coordinate
   localparam logic [COORD_W:0]   G_LO       = (COORD_W+1)'(9);
   localparam logic [COORD_W:0]   G_HI       = (COORD_W+1)'(889);
   localparam logic [COORD_W:0]   G_OFS      = (COORD_W+1)'(10);

   typedef enum logic {S_PLAY = 1'b0, S_DEAD = 1'b1} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [CNT_W-1:0]      r_dead_cnt;
   logic [CNT_W-1:0]      w_dead_cnt_next;
   logic                  r_coll;
   logic                  r_score_reset;
   logic                  w_score_reset_next;
   logic                  w_play_tick;
   logic                  w_die;
   logic                  w_advance;
   logic                  w_hold;
   logic [NUM_WALLS-1:0]  w_wrap;
   logic                  w_any_wrap;
   logic [COORD_W-1:0]    w_speed;
   logic [COORD_W-1:0]    r_blk_x;
   logic [COORD_W-1:0]    r_blk_y;
   logic [COORD_W-1:0]    w_blk_x_next;
   logic [COORD_W-1:0]    w_blk_y_next;
   logic [COORD_W-1:0]    r_gap_size;

   // A PLAY tick either kills the player (latched or same-cycle collision) or advances the game
   assign w_play_tick = tick && (r_state == S_PLAY);
   assign w_die       = w_play_tick && (r_coll || collide);
   assign w_advance   = w_play_tick && !w_die;
   // Positions sit at their reset values whenever we are (or are about to be) dead
   assign w_hold      = reset || w_die || (r_state == S_DEAD);
   assign w_any_wrap  = |w_wrap;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_DEAD;
         r_dead_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_dead_cnt <= w_dead_cnt_next;
      end
   end

   // Next-state logic: respawn countdown in DEAD, death on collision in PLAY
   always_comb begin
      w_state_next    = r_state;
      w_dead_cnt_next = r_dead_cnt;
      case (r_state)
         S_DEAD: begin
            if (tick) begin
               if (r_dead_cnt == CNT_LAST) begin
                  w_state_next    = S_PLAY;
                  w_dead_cnt_next = '0;
               end else begin
                  w_dead_cnt_next = r_dead_cnt + 1'b1;
               end
            end
         end
         S_PLAY: begin
            if (w_die) begin
               w_state_next    = S_DEAD;
               w_dead_cnt_next = '0;
            end
         end
         default: begin
            w_state_next    = S_DEAD;
            w_dead_cnt_next = '0;
         end
      endcase
   end

   // Output decode: score_reset covers the last 40 counts of the dead phase
   always_comb begin
      w_score_reset_next = (w_state_next == S_DEAD) &&
                           (w_dead_cnt_next >= CNT_SR_LO) &&
                           (w_dead_cnt_next <= CNT_LAST);
   end

   // Registered score_reset so it lines up with the registered state/counter
   always_ff @(posedge clk) begin
      if (reset) r_score_reset <= 1'b0;
      else       r_score_reset <= w_score_reset_next;
   end

   assign score_reset = r_score_reset;
   assign dead        = (r_state == S_DEAD);
   assign score_stop  = (r_state == S_DEAD);

   // Collision latch: catches pulses between ticks, consumed by every tick
   always_ff @(posedge clk) begin
      if (reset || r_state == S_DEAD || tick) r_coll <= 1'b0;
      else if (collide)                       r_coll <= 1'b1;
   end

`ifdef WALL_ENGINE_SPEEDUP_EN
   localparam logic [COORD_W-1:0] SPD_BASE = COORD_W'(WALL_STEP);
   localparam logic [COORD_W-1:0] SPD_MAX  = COORD_W'(2 * WALL_STEP);
   logic [COORD_W-1:0] r_speed;
   logic [1:0]         r_wrap_cnt;

   // Speed ramp: +1 every fourth wrapping tick, saturating, reset on death
   always_ff @(posedge clk) begin
      if (reset || w_die) begin
         r_speed    <= SPD_BASE;
         r_wrap_cnt <= 2'd0;
      end else if (w_advance && w_any_wrap) begin
         r_wrap_cnt <= r_wrap_cnt + 2'd1;
         if (r_wrap_cnt == 2'd3 && r_speed < SPD_MAX) r_speed <= r_speed + 1'b1;
      end
   end

   assign w_speed = r_speed;
`else
   assign w_speed = COORD_W'(WALL_STEP);
`endif

   // Per-wall scroll, wrap and gap relocation
   generate
      for (genvar gi = 0; gi < NUM_WALLS; gi++) begin : g_wall
         localparam logic [COORD_W-1:0] WALL_INIT = COORD_W'(gi * ((WALL_WRAP + 1) / NUM_WALLS));
         logic [COORD_W-1:0] r_wall_x;
         logic [COORD_W-1:0] r_gap_y;
         logic [COORD_W-1:0] w_gap_y_wrap;
         logic [COORD_W:0]   w_g;
         logic [COORD_W:0]   w_up_sum;
         logic [COORD_W:0]   w_dn_sum;

         assign w_wrap[gi] = (r_wall_x > WRAP_C);
         assign w_g        = {1'b0, r_gap_y};
         // Move the gap towards whichever side of the play field has more room
         assign w_up_sum   = ((G_HI + w_g) >> 1) + G_OFS;
         assign w_dn_sum   = ((G_LO + w_g) >> 1) - G_OFS;
         assign w_gap_y_wrap = ((w_g - G_LO) < (G_HI - w_g)) ? w_up_sum[COORD_W-1:0]
                                                             : w_dn_sum[COORD_W-1:0];

         // Wall register: reload while dead, scroll or wrap on a play tick
         always_ff @(posedge clk) begin
            if (w_hold) begin
               r_wall_x <= WALL_INIT;
               r_gap_y  <= GAP_Y_INIT;
            end else if (w_advance) begin
               if (w_wrap[gi]) begin
                  r_wall_x <= '0;
                  r_gap_y  <= w_gap_y_wrap;
               end else begin
                  r_wall_x <= r_wall_x + w_speed;
               end
            end
         end

         assign wall_x[gi*COORD_W +: COORD_W] = r_wall_x;
         assign gap_y[gi*COORD_W +: COORD_W]  = r_gap_y;
      end
   endgenerate

   // Shared gap shrinks once per wrapping tick, however many walls wrapped
   always_ff @(posedge clk) begin
      if (w_hold)                                                 r_gap_size <= GAP_INIT_C;
      else if (w_advance && w_any_wrap && r_gap_size > GAP_MIN_C) r_gap_size <= r_gap_size - GAP_DEC_C;
   end

   assign gap_size = r_gap_size;

   // Block movement: opposing buttons cancel, steps clamp exactly to the bounds
   always_comb begin
      w_blk_x_next = r_blk_x;
      w_blk_y_next = r_blk_y;
      if (sw_left && !sw_right)
         w_blk_x_next = (r_blk_x < X_LO_TH) ? X_MIN : r_blk_x - STEP;
      else if (sw_right && !sw_left)
         w_blk_x_next = (r_blk_x > X_HI_TH) ? X_MAX : r_blk_x + STEP;
      if (sw_up && !sw_down)
         w_blk_y_next = (r_blk_y < Y_LO_TH) ? Y_MIN : r_blk_y - STEP;
      else if (sw_down && !sw_up)
         w_blk_y_next = (r_blk_y > Y_HI_TH) ? Y_MAX : r_blk_y + STEP;
   end

   // Block register
   always_ff @(posedge clk) begin
      if (w_hold) begin
         r_blk_x <= BLK_X_INIT;
         r_blk_y <= BLK_Y_INIT;
      end else if (w_advance) begin
         r_blk_x <= w_blk_x_next;
         r_blk_y <= w_blk_y_next;
      end
   end

   assign blk_x = r_blk_x;
   assign blk_y = r_blk_y;

endmodule
